// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with master-to-slave mux
// and a watchdog that terminates unanswered accesses.
module bus_arbiter_rr #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  localparam int OW = $clog2(N_MASTERS),
  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        m_req_,
  output logic [N_MASTERS-1:0]        m_grnt_,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS-1:0]        m_as_,
  input  logic [N_MASTERS-1:0]        m_rw,
  input  logic [N_MASTERS*DATA_W-1:0] m_wr_data,
  output logic [DATA_W-1:0]           m_rd_data,
  output logic [N_MASTERS-1:0]        m_rdy_,
  output logic [ADDR_W-1:0]           s_addr,
  output logic                        s_as_,
  output logic                        s_rw,
  output logic [DATA_W-1:0]           s_wr_data,
  input  logic [DATA_W-1:0]           s_rd_data,
  input  logic                        s_rdy_,
  output logic [OW-1:0]               owner,
  output logic                        busy,
  output logic                        timeout_err
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_e;

  state_e               state_q;
  logic [OW-1:0]        owner_q;
  logic [N_MASTERS-1:0] grnt_q;
  logic                 pending_q;
  logic [CW-1:0]        cnt_q;

  logic                 owned;
  logic                 own_req;
  logic                 own_as;
  logic                 fire;
  logic                 any_req;
  logic [OW-1:0]        win;
  logic [N_MASTERS-1:0] win_oh;
  int                   idx;

  assign owned   = (state_q == OWNED);
  assign own_req = ~m_req_[owner_q];
  assign own_as  = ~m_as_[owner_q];

  // A slave answering in the firing cycle wins.
  assign fire = (TIMEOUT != 0) && owned &&
                pending_q && s_rdy_ &&
                (cnt_q == CW'(TIMEOUT));

  // Search starts just past the last owner.
  always_comb begin
    any_req = 1'b0;
    win     = owner_q;
    idx     = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = (int'(owner_q) + k) % N_MASTERS;
      if (!any_req && !m_req_[idx]) begin
        any_req = 1'b1;
        win     = OW'(idx);
      end
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OW'(N_MASTERS - 1);
      grnt_q    <= '1;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= OWNED;
            owner_q <= win;
            grnt_q  <= ~win_oh;
          end
        end
        OWNED: begin
          if (!own_req) begin
            if (any_req) begin
              owner_q <= win;
              grnt_q  <= ~win_oh;
            end else begin
              state_q <= IDLE;
              grnt_q  <= '1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grnt_q  <= '1;
        end
      endcase

      if (!owned || !own_req || !s_rdy_ || fire) begin
        pending_q <= 1'b0;
        cnt_q     <= '0;
      end else if (pending_q) begin
        cnt_q <= (TIMEOUT != 0) ? cnt_q + CW'(1) : '0;
      end else if (own_as) begin
        pending_q <= 1'b1;
        cnt_q     <= (TIMEOUT != 0) ? CW'(1) : '0;
      end
    end
  end

  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    m_rd_data = '0;
    m_rdy_    = '1;
    if (owned) begin
      s_addr    = m_addr[int'(owner_q)*ADDR_W +: ADDR_W];
      s_as_     = m_as_[owner_q];
      s_rw      = m_rw[owner_q];
      s_wr_data =
        m_wr_data[int'(owner_q)*DATA_W +: DATA_W];
      m_rd_data = fire ? '0 : s_rd_data;
      m_rdy_[owner_q] = fire ? 1'b0 : s_rdy_;
    end
  end

  assign m_grnt_     = grnt_q;
  assign owner       = owner_q;
  assign busy        = owned;
  assign timeout_err = fire;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: arbitration,
// mux routing, watchdog and reset behaviour.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  m_req_;
  logic [N-1:0]  m_grnt_;
  logic [N*AW-1:0] m_addr;
  logic [N-1:0]  m_as_;
  logic [N-1:0]  m_rw;
  logic [N*DW-1:0] m_wr_data;
  logic [DW-1:0] m_rd_data;
  logic [N-1:0]  m_rdy_;
  logic [AW-1:0] s_addr;
  logic          s_as_;
  logic          s_rw;
  logic [DW-1:0] s_wr_data;
  logic [DW-1:0] s_rd_data;
  logic          s_rdy_;
  logic [1:0]    owner;
  logic          busy;
  logic          timeout_err;

  int n_chk = 0;
  int n_err = 0;

  bus_arbiter_rr #(
    .N_MASTERS(N), .ADDR_W(AW),
    .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_(m_req_), .m_grnt_(m_grnt_),
    .m_addr(m_addr), .m_as_(m_as_),
    .m_rw(m_rw), .m_wr_data(m_wr_data),
    .m_rd_data(m_rd_data), .m_rdy_(m_rdy_),
    .s_addr(s_addr), .s_as_(s_as_),
    .s_rw(s_rw), .s_wr_data(s_wr_data),
    .s_rd_data(s_rd_data), .s_rdy_(s_rdy_),
    .owner(owner), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] seq [0:4];
  logic         seen;

  initial begin
    seq[0] = 4'b1110; seq[1] = 4'b1101;
    seq[2] = 4'b1011; seq[3] = 4'b0111;
    seq[4] = 4'b1110;
    rst = 1'b1; m_req_ = '1; m_as_ = '1;
    m_rw = '1; s_rdy_ = 1'b1; s_rd_data = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]    = AW'(30'h100 + i);
      m_wr_data[i*DW +: DW] = 32'hD000_0000 + i;
    end
    tick(); tick();
    rst = 1'b0; #1;

    chk("rst_grnt", 64'(m_grnt_), 64'hF);
    chk("rst_owner", 64'(owner), 64'd3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    chk("rst_sas", 64'(s_as_), 64'd1);
    chk("rst_saddr", 64'(s_addr), 64'd0);
    chk("rst_rdy", 64'(m_rdy_), 64'hF);

    // single request from master 2
    m_req_ = 4'b1011; #1;
    chk("t1_pre", 64'(m_grnt_), 64'hF);
    tick();
    chk("t1_grnt", 64'(m_grnt_), 64'b1011);
    chk("t1_owner", 64'(owner), 64'd2);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_saddr", 64'(s_addr), 64'h102);
    chk("t1_swd", 64'(s_wr_data), 64'hD000_0002);
    m_req_ = '1;
    tick();
    chk("t1_rel", 64'(m_grnt_), 64'hF);

    // round-robin from reset
    rst = 1'b1; tick(); rst = 1'b0;
    m_req_ = 4'b0000;
    tick();
    chk("rr_first", 64'(m_grnt_), 64'(seq[0]));
    for (int k = 0; k < 4; k++) begin
      m_req_ = 4'b0001 << k;
      tick();
      chk("rr_grnt", 64'(m_grnt_), 64'(seq[k+1]));
      chk("rr_busy", 64'(busy), 64'd1);
      chk("rr_owner", 64'(owner), 64'((k + 1) % 4));
      m_req_ = 4'b0000;
    end
    m_req_ = '1;
    tick();
    chk("rr_idle", 64'(busy), 64'd0);
    chk("rr_last", 64'(owner), 64'd0);

    // master 1 read, master 3 strobing
    m_req_ = 4'b1101;
    tick();
    chk("rd_grnt", 64'(m_grnt_), 64'b1101);
    m_req_ = 4'b0101; m_as_ = 4'b0111; #1;
    chk("rd_iso", 64'(s_as_), 64'd1);
    chk("rd_addr", 64'(s_addr), 64'h101);
    chk("rd_nrdy", 64'(m_rdy_), 64'hF);
    tick();
    chk("rd_nopre", 64'(m_grnt_), 64'b1101);
    m_as_ = 4'b0101; s_rdy_ = 1'b0;
    s_rd_data = 32'hCAFE_0001; #1;
    chk("rd_sas", 64'(s_as_), 64'd0);
    chk("rd_srw", 64'(s_rw), 64'd1);
    chk("rd_rdy", 64'(m_rdy_), 64'b1101);
    chk("rd_data", 64'(m_rd_data), 64'hCAFE_0001);
    tick();
    m_as_ = '1; s_rdy_ = 1'b1; m_req_ = 4'b0111;
    tick();
    chk("rd_hand", 64'(m_grnt_), 64'b0111);
    m_req_ = '1;
    tick();
    chk("rd_idle", 64'(busy), 64'd0);

    // watchdog fires on master 0
    s_rd_data = 32'h1234_5678;
    m_req_ = 4'b1110;
    tick();
    chk("wd_grnt", 64'(m_grnt_), 64'b1110);
    m_as_ = 4'b1110;
    tick();
    m_as_ = '1;
    for (int c = 1; c < TO; c++) begin
      #1;
      chk("wd_early", 64'(timeout_err), 64'd0);
      tick();
    end
    #1;
    chk("wd_terr", 64'(timeout_err), 64'd1);
    chk("wd_rdy", 64'(m_rdy_), 64'b1110);
    chk("wd_data", 64'(m_rd_data), 64'd0);
    tick();
    chk("wd_pulse", 64'(timeout_err), 64'd0);
    chk("wd_rdy1", 64'(m_rdy_), 64'hF);

    // slave answers on the firing cycle
    m_as_ = 4'b1110;
    tick();
    m_as_ = '1;
    for (int c = 1; c < TO; c++) tick();
    s_rdy_ = 1'b0; #1;
    chk("sup_terr", 64'(timeout_err), 64'd0);
    chk("sup_rdy", 64'(m_rdy_), 64'b1110);
    chk("sup_data", 64'(m_rd_data), 64'h1234_5678);
    tick();
    s_rdy_ = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1; seen = seen | timeout_err;
      tick();
    end
    chk("sup_quiet", 64'(seen), 64'd0);

    // release with pending set, handover to 2
    m_as_ = 4'b1110;
    tick();
    m_as_ = '1;
    tick(); tick();
    m_req_ = 4'b1011;
    tick();
    chk("ab_grnt", 64'(m_grnt_), 64'b1011);
    chk("ab_owner", 64'(owner), 64'd2);
    m_as_ = 4'b1011;
    tick();
    m_as_ = '1;
    seen = 1'b0;
    for (int c = 1; c < TO; c++) begin
      #1; seen = seen | timeout_err;
      tick();
    end
    chk("ab_early", 64'(seen), 64'd0);
    #1;
    chk("ab_terr", 64'(timeout_err), 64'd1);
    chk("ab_rdy", 64'(m_rdy_), 64'b1011);
    tick();

    // lone owner re-request after one idle cycle
    m_req_ = 4'b0111;
    tick();
    chk("re_grnt", 64'(m_grnt_), 64'b0111);
    m_req_ = '1;
    tick();
    chk("re_idle", 64'(busy), 64'd0);
    m_req_ = 4'b0111;
    tick();
    chk("re_again", 64'(m_grnt_), 64'b0111);

    // reset mid-access by master 3
    m_as_ = 4'b0111;
    tick();
    m_as_ = '1;
    rst = 1'b1; s_rdy_ = 1'b0;
    tick();
    chk("mr_grnt", 64'(m_grnt_), 64'hF);
    chk("mr_owner", 64'(owner), 64'd3);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_rdy", 64'(m_rdy_), 64'hF);
    chk("mr_terr", 64'(timeout_err), 64'd0);
    rst = 1'b0; s_rdy_ = 1'b1; m_req_ = '1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin arbiter and master multiplexer for the shared system bus. It grants bus ownership to one of N bus masters (CPU fetch/memory bus interfaces, DMA) using active-low `req_`/`grnt_` handshakes. It routes the owner's address, strobe and write data to the slave side and returns `rdy_` only to the owner. A watchdog terminates accesses whose slave never answers, so no master stalls forever.

## Interface
Parameters:
- `N_MASTERS`, 4: number of requesters; 2..8.
- `ADDR_W`, 30: word address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: max cycles an access may wait for `s_rdy_`; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `m_req_`  in  N_MASTERS  per-master bus request, active-low.
- `m_grnt_`  out  N_MASTERS  per-master grant, active-low, registered, one-hot-low.
- `m_addr`  in  N_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W].
- `m_as_`  in  N_MASTERS  address strobe, active-low.
- `m_rw`  in  N_MASTERS  1 = read, 0 = write.
- `m_wr_data`  in  N_MASTERS*DATA_W  packed write data.
- `m_rd_data`  out  DATA_W  read data, broadcast to all masters.
- `m_rdy_`  out  N_MASTERS  per-master ready, active-low.
- `s_addr`  out  ADDR_W  address to slaves.
- `s_as_`  out  1  strobe to slaves.
- `s_rw`  out  1  direction to slaves.
- `s_wr_data`  out  DATA_W  write data to slaves.
- `s_rd_data`  in  DATA_W  slave read data.
- `s_rdy_`  in  1  slave ready, active-low.
- `owner`  out  $clog2(N_MASTERS)  index of the current or last owner.
- `busy`  out  1  high while a grant is held.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: `IDLE` (no grant) and `OWNED` (exactly one `m_grnt_` bit low).
- Arbitration is round-robin. The search starts at `owner+1` and wraps modulo N_MASTERS; the first master with `m_req_` low wins.
- `IDLE`: if any request is present, grant the winner, load `owner`, go to `OWNED`.
- `OWNED`, owner's `m_req_` still low: keep the grant. Other requests are ignored; there is no preemption.
- `OWNED`, owner's `m_req_` high: release the grant.
  - If other requests are present, grant the next winner on the same edge (no idle gap) and stay in `OWNED`.
  - Otherwise go to `IDLE`.
- Slave-side mux, combinational:
  - In `OWNED`, `s_addr`/`s_as_`/`s_rw`/`s_wr_data` follow the owner's inputs.
  - Otherwise they are 0 / 1 / 1 / 0.
  - Non-owner strobes never reach the slaves.
- `m_rd_data` = `s_rd_data` while `OWNED`, otherwise 0. While the watchdog fires it is forced to 0.
- `m_rdy_[owner]` = `s_rdy_` while `OWNED`. All other `m_rdy_` bits stay 1.
- Watchdog:
  - `pending` sets on owner `s_as_` low and clears on `s_rdy_` low.
  - The counter increments each cycle `pending` is set and resets to 0 when `pending` clears.
  - When the count reaches `TIMEOUT`, the arbiter drives `m_rdy_[owner]` low for one cycle with `m_rd_data` = 0, pulses `timeout_err`, and clears `pending`.
- `busy` = (state == `OWNED`).

## Timing
- Reset values: state `IDLE`; `m_grnt_` all 1; `owner` = N_MASTERS-1, so master 0 has first priority; `busy` 0; `timeout_err` 0; `pending` 0; counter 0. Slave outputs take their idle values.
- Grant latency: `m_req_` low sampled at edge k gives `m_grnt_` low after edge k. That is one cycle from request to grant when idle.
- Handover: owner `m_req_` high sampled at edge k gives the old grant high and the new grant low, both after edge k.
- The owner's first `m_as_` is accepted in the cycle after `m_grnt_` goes low.
- Watchdog fires in cycle `TIMEOUT` after the strobe cycle if `s_rdy_` never goes low.
- Boundary conditions:
  - `s_rdy_` low in the same cycle the watchdog would fire: normal completion, no `timeout_err`.
  - Owner releases `m_req_` while `pending` is set: the access is abandoned, `pending` and the counter clear, and the grant moves normally.
  - All masters request at once from reset: order is 0,1,2,3,0…
  - Only the owner requests after its release: it is re-granted after one `IDLE` cycle.
  - `rst` mid-access: all grants drop after the next edge, and any in-flight `s_rdy_` is ignored.

## Test plan
- Reset, then master 2 requests -> `m_grnt_`=4'b1011 one cycle later, `owner`=2, `busy`=1, `s_addr`=`m_addr[2]`.
- All four hold `m_req_` low, each releasing after one access -> grant order 0,1,2,3,0 with back-to-back handover and no idle cycles.
- Master 1 owns and reads, slave returns `s_rd_data`=32'hCAFE_0001 with `s_rdy_` low -> `m_rdy_`=4'b1101 and `m_rd_data`=32'hCAFE_0001 that cycle; master 3 strobing concurrently never reaches `s_as_`.
- `TIMEOUT`=8, master 0 strobes, slave silent -> on cycle 8 `m_rdy_[0]`=0, `m_rd_data`=0, `timeout_err`=1 for exactly one cycle; `s_rdy_` arriving on cycle 8 instead suppresses `timeout_err`.
- Master 0 owns with `pending` set, then releases while master 2 requests -> grant moves to 2 on the next edge and the counter restarts at 0.
- `rst` asserted while master 3 owns -> `m_grnt_`=4'b1111, `owner`=3 (reset value), `busy`=0 after the edge.
